// File: rtl/audio_bank_pkg.sv
// Shared types and constants for the audio channel bank: register offsets, CTL/GCTL fields, noise selects.
// AUDIO_BANK_ENVELOPE_EN widens CTL storage to keep the envelope rate field.
package audio_bank_pkg;

  localparam int REG_FREQ_OFS    = 0;
  localparam int REG_CTL_OFS     = 1;

  localparam int CTL_VOL_LSB     = 0;
  localparam int CTL_VOLONLY_BIT = 4;
  localparam int CTL_NSEL_LSB    = 5;
  localparam int CTL_RATE_LSB    = 8;

  localparam int GCTL_SLOW_BIT   = 0;
  localparam int GCTL_POLY9_BIT  = 1;
  localparam int GCTL_EN_BIT     = 2;

  localparam int DEF_FAST_DIV    = 56;
  localparam int DEF_SLOW_DIV    = 1563;

  typedef enum logic [2:0] {
    NS_R5_R17 = 3'b000,
    NS_R5     = 3'b001,
    NS_R4_R5  = 3'b010,
    NS_R5_B   = 3'b011,
    NS_R17    = 3'b100,
    NS_TONE   = 3'b101,
    NS_R4     = 3'b110,
    NS_TONE_B = 3'b111
  } noise_sel_e;

  typedef struct packed {
    logic [3:0] rate;
    noise_sel_e nsel;
    logic       vol_only;
    logic [3:0] vol;
  } ctl_t;

  function automatic logic noise_pick(noise_sel_e sel, logic r4, logic r5, logic r17);
    logic res;
    case (sel)
      NS_R5_R17:     res = r5 & r17;
      NS_R5, NS_R5_B: res = r5;
      NS_R4_R5:      res = r4 & r5;
      NS_R17:        res = r17;
      NS_R4:         res = r4;
      default:       res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/audio_bank_channel.sv
// One tone/noise channel: divider, square, noise sample, optional envelope (AUDIO_BANK_ENVELOPE_EN).
// Latency: square toggles on the base tick that finds count==0; no backpressure.
module audio_bank_channel
  import audio_bank_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             clrBar,
  input  logic             base_tick_i,
  input  logic [DIV_W-1:0] freq_i,
  input  ctl_t             ctl_i,
  input  logic             r4_i,
  input  logic             r5_i,
  input  logic             r17_i,
`ifdef AUDIO_BANK_ENVELOPE_EN
  input  logic             slow_tick_i,
  input  logic             ctl_ld_i,
  input  logic [3:0]       ld_vol_i,
`endif
  output logic [3:0]       level_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             smp_q, smp_d;
  logic [3:0]       eff_vol;

  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    smp_d = smp_q;
    if (base_tick_i) begin
      if (cnt_q == '0) begin
        cnt_d = freq_i;
        sq_d  = ~sq_q;
        // noise is latched only on the rising square edge
        if (!sq_q) smp_d = noise_pick(ctl_i.nsel, r4_i, r5_i, r17_i);
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
      smp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
      smp_q <= smp_d;
    end
  end

`ifdef AUDIO_BANK_ENVELOPE_EN
  logic [3:0] env_q, env_d;
  logic [7:0] ediv_q, ediv_d;
  logic [7:0] ediv_last;

  // decay step every 16*rate slow ticks
  assign ediv_last = {ctl_i.rate - 4'd1, 4'hF};

  always_comb begin
    env_d  = env_q;
    ediv_d = ediv_q;
    if (ctl_ld_i) begin
      env_d  = ld_vol_i;
      ediv_d = '0;
    end else if (slow_tick_i && ctl_i.rate != 4'h0) begin
      if (ediv_q == ediv_last) begin
        ediv_d = '0;
        if (env_q != 4'h0) env_d = env_q - 1'b1;
      end else begin
        ediv_d = ediv_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      env_q  <= '0;
      ediv_q <= '0;
    end else begin
      env_q  <= env_d;
      ediv_q <= ediv_d;
    end
  end

  assign eff_vol = env_q;
`else
  logic unused_rate;
  assign unused_rate = ^ctl_i.rate;
  assign eff_vol     = ctl_i.vol;
`endif

  assign level_o = ((sq_q & smp_q) | ctl_i.vol_only) ? eff_vol : 4'h0;

endmodule

// File: rtl/audio_channel_bank.sv
// NUM_CH tone/noise channels with prescaler, LFSR noise, register file and PWM mixer (AUDIO_BANK_ENVELOPE_EN adds envelopes).
// Latency: writes visible next cycle, rdata one cycle after rd_en, aud one cycle after level change; no backpressure.
module audio_channel_bank
  import audio_bank_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DIV_W    = 16,
  parameter int FAST_DIV = DEF_FAST_DIV,
  parameter int SLOW_DIV = DEF_SLOW_DIV
) (
  input  logic        clk,
  input  logic        clrBar,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [4:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        aud
);

  localparam int SUM_W  = 4 + $clog2(NUM_CH);
  localparam int FCNT_W = $clog2(FAST_DIV + 1);
  localparam int SCNT_W = $clog2(SLOW_DIV + 1);
  localparam logic [4:0] GCTL_ADDR = 5'(2 * NUM_CH);
  localparam logic [4:0] RNG_ADDR  = 5'(2 * NUM_CH + 1);

  logic [DIV_W-1:0] freq_q [NUM_CH];
  ctl_t             ctl_q  [NUM_CH];
  logic [2:0]       gctl_q;
  ctl_t             ctl_wdat;
  logic [15:0]      rd_val;
  logic [15:0]      rdata_q;
  logic             unused_wdata;

  assign unused_wdata      = ^wdata;
  assign ctl_wdat.vol      = wdata[CTL_VOL_LSB +: 4];
  assign ctl_wdat.vol_only = wdata[CTL_VOLONLY_BIT];
  assign ctl_wdat.nsel     = noise_sel_e'(wdata[CTL_NSEL_LSB +: 3]);
`ifdef AUDIO_BANK_ENVELOPE_EN
  assign ctl_wdat.rate     = wdata[CTL_RATE_LSB +: 4];
`else
  assign ctl_wdat.rate     = 4'h0;
`endif

  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      for (int i = 0; i < NUM_CH; i++) begin
        freq_q[i] <= '0;
        ctl_q[i]  <= '0;
      end
      gctl_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == 5'(2 * i + REG_FREQ_OFS)) freq_q[i] <= wdata[DIV_W-1:0];
        if (addr == 5'(2 * i + REG_CTL_OFS))  ctl_q[i]  <= ctl_wdat;
      end
      if (addr == GCTL_ADDR) gctl_q <= wdata[2:0];
    end
  end

  // ---- prescaler ----
  logic              gen_en, fast_tick, slow_tick, base_tick;
  logic [FCNT_W-1:0] fast_cnt_q, fast_cnt_d;
  logic [SCNT_W-1:0] slow_cnt_q, slow_cnt_d;

  assign gen_en    = gctl_q[GCTL_EN_BIT];
  assign fast_tick = gen_en && (fast_cnt_q == FCNT_W'(FAST_DIV - 1));
  assign slow_tick = gen_en && (slow_cnt_q == SCNT_W'(SLOW_DIV - 1));
  assign base_tick = gctl_q[GCTL_SLOW_BIT] ? slow_tick : fast_tick;

  always_comb begin
    fast_cnt_d = fast_cnt_q + 1'b1;
    slow_cnt_d = slow_cnt_q + 1'b1;
    if (!gen_en || fast_tick) fast_cnt_d = '0;
    if (!gen_en || slow_tick) slow_cnt_d = '0;
  end

  // ---- noise sources ----
  logic [3:0]  lfsr4_q;
  logic [4:0]  lfsr5_q;
  logic [16:0] lfsr17_q;
  logic        lfsr17_fb;

  // 9-bit mode reuses the low bits of the long register with x^9+x^5+1
  assign lfsr17_fb = gctl_q[GCTL_POLY9_BIT] ? ~(lfsr17_q[8] ^ lfsr17_q[4])
                                            : ~(lfsr17_q[16] ^ lfsr17_q[13]);

  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      fast_cnt_q <= '0;
      slow_cnt_q <= '0;
      lfsr4_q    <= '0;
      lfsr5_q    <= '0;
      lfsr17_q   <= '0;
    end else begin
      fast_cnt_q <= fast_cnt_d;
      slow_cnt_q <= slow_cnt_d;
      if (fast_tick) begin
        lfsr4_q  <= {lfsr4_q[2:0], ~(lfsr4_q[3] ^ lfsr4_q[2])};
        lfsr5_q  <= {lfsr5_q[3:0], ~(lfsr5_q[4] ^ lfsr5_q[2])};
        lfsr17_q <= {lfsr17_q[15:0], lfsr17_fb};
      end
    end
  end

  // ---- channels ----
  logic [3:0] level [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef AUDIO_BANK_ENVELOPE_EN
    logic ctl_ld;
    assign ctl_ld = wr_en && (addr == 5'(2 * i + REG_CTL_OFS));
`endif
    audio_bank_channel #(.DIV_W(DIV_W)) u_ch (
      .clk         (clk),
      .clrBar      (clrBar),
      .base_tick_i (base_tick),
      .freq_i      (freq_q[i]),
      .ctl_i       (ctl_q[i]),
      .r4_i        (lfsr4_q[0]),
      .r5_i        (lfsr5_q[0]),
      .r17_i       (lfsr17_q[0]),
`ifdef AUDIO_BANK_ENVELOPE_EN
      .slow_tick_i (slow_tick),
      .ctl_ld_i    (ctl_ld),
      .ld_vol_i    (wdata[CTL_VOL_LSB +: 4]),
`endif
      .level_o     (level[i])
    );
  end

  // ---- read port ----
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == 5'(2 * i + REG_FREQ_OFS)) rd_val[DIV_W-1:0] = freq_q[i];
      if (addr == 5'(2 * i + REG_CTL_OFS))  rd_val[11:0]      = ctl_q[i];
    end
    if (addr == GCTL_ADDR) rd_val[2:0] = gctl_q;
    if (addr == RNG_ADDR)  rd_val[7:0] = lfsr17_q[16:9];
  end

  // ---- mixer / PWM ----
  logic [SUM_W-1:0] sum, pwm_cnt_q;
  logic             aud_q;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) sum = sum + SUM_W'(level[i]);
  end

  always_ff @(posedge clk or negedge clrBar) begin
    if (!clrBar) begin
      rdata_q   <= '0;
      pwm_cnt_q <= '0;
      aud_q     <= 1'b0;
    end else begin
      if (rd_en) rdata_q <= rd_val;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      aud_q     <= (pwm_cnt_q < sum);
    end
  end

  assign rdata = rdata_q;
  assign aud   = aud_q;

endmodule

// File: tb/tb_audio_channel_bank.sv
// Directed bench for audio_channel_bank (NUM_CH=4, short tick divisors so tone periods stay small).
// Square-wave timing is observed on channel 0; all levels are observed through aud duty.
module tb_audio_channel_bank;

  logic        clk = 1'b0;
  logic        clrBar = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [4:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        aud;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_channel_bank #(
    .NUM_CH(4), .DIV_W(16), .FAST_DIV(8), .SLOW_DIV(20)
  ) dut (
    .clk(clk), .clrBar(clrBar), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .aud(aud)
  );

  logic sq0;
  assign sq0 = dut.g_ch[0].u_ch.sq_q;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output int d);
    @(negedge clk);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = int'(rdata);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrBar = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (3) @(negedge clk);
    clrBar = 1'b1;
  endtask

  task automatic count_aud(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (aud === 1'b1) c++;
    end
  endtask

  // cycles until channel 0 square changes; -1 if it never does within the bound
  task automatic wait_toggle(output int cyc);
    logic prev;
    prev = sq0;
    cyc  = -1;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      if (sq0 !== prev) begin
        cyc = k;
        break;
      end
    end
  endtask

  int v, c, acc;
  int exp_ctl;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rdata", int'(rdata), 0);
    check("reset_aud", int'(aud), 0);
    clrBar = 1'b1;
    count_aud(64, c);
    check("reset_aud_64", c, 0);
    rd(5'd9, v);
    check("reset_rng", v, 0);

    // register file
    wr(5'd0, 16'h1234);
    rd(5'd0, v);
    check("freq0_rb", v, 'h1234);
    wr(5'd1, 16'hFFFF);
    rd(5'd1, v);
`ifdef AUDIO_BANK_ENVELOPE_EN
    exp_ctl = 'hFFF;
`else
    exp_ctl = 'h0FF;
`endif
    check("ctl0_rb", v, exp_ctl);
    wr(5'd8, 16'hFFFB);
    rd(5'd8, v);
    check("gctl_rb", v, 'h3);
    wr(5'd8, 16'h0000);
    wr(5'd10, 16'h0055);
    rd(5'd10, v);
    check("unmapped10", v, 0);
    rd(5'd31, v);
    check("unmapped31", v, 0);

    // same-cycle read and write
    wr(5'd2, 16'h00AA);
    @(negedge clk);
    wr_en = 1'b1; rd_en = 1'b1; addr = 5'd2; wdata = 16'h00BB;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check("rw_old", int'(rdata), 'hAA);
    rd(5'd2, v);
    check("rw_new", v, 'hBB);

    // vol-only mixing
    do_reset();
    wr(5'd1, 16'h001A);
    repeat (4) @(negedge clk);
    count_aud(64, c);
    check("volonly_10", c, 10);
    wr(5'd3, 16'h001F);
    wr(5'd5, 16'h001F);
    wr(5'd7, 16'h001F);
    wr(5'd1, 16'h001F);
    repeat (4) @(negedge clk);
    count_aud(64, c);
    check("volonly_60", c, 60);

    // tone timing, fast base (8 clk per tick)
    do_reset();
    wr(5'd1, 16'h00EF);
    wr(5'd8, 16'h0004);
    wait_toggle(v);
    wait_toggle(v);
    check("half_freq0", v, 8);
    wr(5'd0, 16'h0003);
    wait_toggle(v);
    wait_toggle(v);
    check("half_freq3_a", v, 32);
    wait_toggle(v);
    check("half_freq3_b", v, 32);
    wr_en = 1'b1; addr = 5'd0; wdata = 16'h0007;
    wait_toggle(v);
    check("half_midcount", v, 32);
    wait_toggle(v);
    check("half_freq7", v, 64);
    count_aud(1280, c);
    check("tone_duty", c, 150);

    // disable freezes the square
    wr(5'd8, 16'h0000);
    c = 0;
    begin
      logic prev;
      prev = sq0;
      repeat (300) begin
        @(negedge clk);
        if (sq0 !== prev) c++;
        prev = sq0;
      end
    end
    check("freeze", c, 0);

    // slow base (20 clk per tick)
    wr(5'd8, 16'h0005);
    wait_toggle(v);
    wait_toggle(v);
    check("half_slow", v, 160);

    acc = 0;
    for (int k = 0; k < 4; k++) begin
      rd(5'd9, v);
      check("rng_hi", v >> 8, 0);
      acc |= v;
      repeat (128) @(negedge clk);
    end
    check("rng_running", int'(acc != 0), 1);

    // reset mid-operation aborts a concurrent write
    @(negedge clk);
    wr_en = 1'b1; addr = 5'd8; wdata = 16'h0003; clrBar = 1'b0;
    @(negedge clk);
    wr_en = 1'b0;
    check("midrst_aud", int'(aud), 0);
    clrBar = 1'b1;
    rd(5'd8, v);
    check("midrst_gctl", v, 0);
    rd(5'd0, v);
    check("midrst_freq0", v, 0);
    count_aud(64, c);
    check("midrst_aud_64", c, 0);

    wr(5'd1, 16'h011F);
    rd(5'd1, v);
`ifdef AUDIO_BANK_ENVELOPE_EN
    check("ctl_11f", v, 'h11F);
    do_reset();
    wr(5'd8, 16'h0004);
    wr(5'd1, 16'h011F);
    repeat (4) @(negedge clk);
    count_aud(64, c);
    check("env_start", c, 15);
    repeat (15 * 16 * 20 + 200) @(negedge clk);
    count_aud(64, c);
    check("env_floor", c, 0);
`else
    check("ctl_11f", v, 'h01F);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
